// File: rtl/trace_scheduler_pkg.sv
// trace_scheduler_pkg
// Shared constants and the sequencer state encoding for the frame-level
// trace scheduler and its block-address generator.
//   DEF_COLS / DEF_ROWS   : block grid size (blocks per row, block rows)
//   DEF_COL_W / DEF_ROW_W : column / row address widths
//   DEF_DATA_W            : pixel colour width
//   DEF_MAX_OUT           : default credit limit for outstanding jobs
//   OBJ_W / OUT_W         : object bus width, outstanding counter width
package trace_scheduler_pkg;

  localparam int DEF_COLS    = 80;
  localparam int DEF_ROWS    = 60;
  localparam int DEF_COL_W   = 7;
  localparam int DEF_ROW_W   = 6;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_MAX_OUT = 4;
  localparam int OBJ_W       = 128;
  localparam int OUT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/trace_addr_gen.sv
// trace_addr_gen
// Row-major block address counter. Walks (col,row) from (0,0) to
// (COLS-1,ROWS-1) one step per advance and wraps back to (0,0).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart at (0,0) (takes priority over advance)
//   advance   : step to the next block in row-major order
//   col, row  : current block address
//   last      : current address is the final block of the frame
module trace_addr_gen
  import trace_scheduler_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(COLS - 1));
  assign row_end = (row == ROW_W'(ROWS - 1));
  assign last    = col_end && row_end;

  // Wrapping from the last block back to (0,0) keeps row inside the grid
  // even though the sequencer stops issuing after the last block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/trace_scheduler.sv
// trace_scheduler
// Frame-level sequencer between the object system, the ray tracer and the
// pixel RAM. A frame request snapshots the object bus, then one trace job
// per block is issued in row-major order under a credit limit; returned
// colours are forwarded as registered pixel-RAM writes.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   frame_sync            : one-cycle frame request
//   obj_bus / obj_snap    : live object state / state latched at frame start
//   job_valid/ready/col/row : trace job handshake
//   res_valid/col/row/color : tracer results (no backpressure)
//   ram_we/addr/din       : pixel-RAM write port, addr = {col,row}
//   busy                  : frame in progress
//   frame_done, overrun, spurious : one-cycle status pulses
//   outstanding           : jobs issued but not yet returned
module trace_scheduler
  import trace_scheduler_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int COL_W   = DEF_COL_W,
  parameter int ROW_W   = DEF_ROW_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_sync,
  input  logic [OBJ_W-1:0]       obj_bus,
  output logic [OBJ_W-1:0]       obj_snap,
  output logic                   job_valid,
  input  logic                   job_ready,
  output logic [COL_W-1:0]       job_col,
  output logic [ROW_W-1:0]       job_row,
  input  logic                   res_valid,
  input  logic [COL_W-1:0]       res_col,
  input  logic [ROW_W-1:0]       res_row,
  input  logic [DATA_W-1:0]      res_color,
  output logic                   ram_we,
  output logic [COL_W+ROW_W-1:0] ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   spurious,
  output logic [OUT_W-1:0]       outstanding
);

  sched_state_t state;
  sched_state_t state_next;
  logic         pending;
  logic         frame_start;
  logic         accept;
  logic         last_job;
  logic         res_counts;

  assign job_valid  = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUT));
  assign accept     = job_valid && job_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // A result only retires credit when something is actually outstanding,
  // or when a job is accepted in the same cycle (net change zero).
  assign res_counts = res_valid && ((outstanding != '0) || accept);

  trace_addr_gen #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_start),
    .advance (accept),
    .col     (job_col),
    .row     (job_row),
    .last    (last_job)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A sync arriving during DONE itself is treated like an already queued
  // request so it is never stranded in the pending flag after returning
  // to IDLE.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (frame_sync) begin
          state_next  = ISSUE;
          frame_start = 1'b1;
        end
      end
      ISSUE: begin
        if (accept && last_job) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding == '0) && !ram_we) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (pending || frame_sync) begin
          state_next  = ISSUE;
          frame_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      overrun  <= 1'b0;
      obj_snap <= '0;
    end else begin
      overrun <= frame_sync && (state != IDLE);
      if (frame_start) begin
        pending  <= 1'b0;
        obj_snap <= obj_bus;
      end else if (frame_sync && (state != IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      spurious    <= 1'b0;
    end else begin
      spurious <= res_valid && !res_counts;
      case ({accept, res_counts})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Every result becomes exactly one write a cycle later, spurious or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= res_valid;
      if (res_valid) begin
        ram_addr <= {res_col, res_row};
        ram_din  <= res_color;
      end
    end
  end

endmodule

// File: tb/tb_trace_scheduler.sv
// tb_trace_scheduler
// Directed bench for trace_scheduler on a 4x2 block grid with a credit
// limit of 4. A small tracer model returns colour col+row*4 three cycles
// after each accepted job; job order, writes, credit count and status
// pulses are compared against hand-derived expectations.
module tb_trace_scheduler;

  localparam int TB_COLS    = 4;
  localparam int TB_ROWS    = 2;
  localparam int TB_COL_W   = 7;
  localparam int TB_ROW_W   = 6;
  localparam int TB_DATA_W  = 12;
  localparam int TB_MAX_OUT = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         frame_sync;
  logic [127:0]                 obj_bus;
  logic [127:0]                 obj_snap;
  logic                         job_valid;
  logic                         job_ready;
  logic [TB_COL_W-1:0]          job_col;
  logic [TB_ROW_W-1:0]          job_row;
  logic                         res_valid;
  logic [TB_COL_W-1:0]          res_col;
  logic [TB_ROW_W-1:0]          res_row;
  logic [TB_DATA_W-1:0]         res_color;
  logic                         ram_we;
  logic [TB_COL_W+TB_ROW_W-1:0] ram_addr;
  logic [TB_DATA_W-1:0]         ram_din;
  logic                         busy;
  logic                         frame_done;
  logic                         overrun;
  logic                         spurious;
  logic [3:0]                   outstanding;

  int total_checks = 0;
  int bad_checks   = 0;
  int ecount       = 0;

  int q_due[$];
  int q_col[$];
  int q_row[$];
  int exp_col, exp_row, exp_out;
  int n_done, n_over, n_acc, n_wr;
  int done_edge, last_res_edge, expect_frames;
  bit wr_pending, prev_done, acc;
  logic [12:0] exp_addr;
  logic [11:0] exp_din;

  trace_scheduler #(
    .COLS    (TB_COLS),
    .ROWS    (TB_ROWS),
    .COL_W   (TB_COL_W),
    .ROW_W   (TB_ROW_W),
    .DATA_W  (TB_DATA_W),
    .MAX_OUT (TB_MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_sync  (frame_sync),
    .obj_bus     (obj_bus),
    .obj_snap    (obj_snap),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_col     (job_col),
    .job_row     (job_row),
    .res_valid   (res_valid),
    .res_col     (res_col),
    .res_row     (res_row),
    .res_color   (res_color),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .spurious    (spurious),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive a frame request with a given object state for one edge.
  task automatic applyStimulus(input logic fs, input logic [127:0] obj);
    frame_sync = fs;
    obj_bus    = obj;
    @(posedge clk);
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic clearModel();
    q_due.delete();
    q_col.delete();
    q_row.delete();
    exp_col = 0; exp_row = 0; exp_out = 0;
    n_done = 0; n_over = 0; n_acc = 0; n_wr = 0;
    done_edge = -1; last_res_edge = -1;
    wr_pending = 1'b0; prev_done = 1'b0;
  endtask

  // Runs the tracer model for ncycles; called and returns at a negedge.
  task automatic runTracer(input int ncycles, input int sync1, input int sync2);
    for (int c = 0; c < ncycles; c++) begin
      if (wr_pending) begin
        checkOutput("ram_we", ram_we, 1'b1);
        checkOutput("ram_addr", ram_addr, exp_addr);
        checkOutput("ram_din", ram_din, exp_din);
        n_wr++;
        wr_pending = 1'b0;
      end else begin
        checkOutput("ram_we_idle", ram_we, 1'b0);
      end
      checkOutput("outstanding", outstanding, exp_out);
      checkOutput("spurious_run", spurious, 1'b0);
      if (prev_done) begin
        if (n_done < expect_frames) begin
          checkOutput("busy_after_done", busy, 1'b1);
          checkOutput("job_valid_after_done", job_valid, 1'b1);
        end else begin
          checkOutput("busy_falls", busy, 1'b0);
        end
      end
      prev_done = frame_done;
      if (frame_done) begin
        n_done++;
        if (n_done == 1) done_edge = ecount;
      end
      if (overrun) n_over++;

      frame_sync = (c == sync1) || (c == sync2);
      res_valid  = 1'b0;
      if (q_due.size() > 0 && q_due[0] == ecount + 1) begin
        res_valid  = 1'b1;
        res_col    = 7'(q_col[0]);
        res_row    = 6'(q_row[0]);
        res_color  = 12'(q_col[0] + q_row[0] * 4);
        exp_addr   = {7'(q_col[0]), 6'(q_row[0])};
        exp_din    = 12'(q_col[0] + q_row[0] * 4);
        wr_pending = 1'b1;
        last_res_edge = ecount + 1;
        void'(q_due.pop_front());
        void'(q_col.pop_front());
        void'(q_row.pop_front());
      end
      acc = job_valid && job_ready;
      if (acc) begin
        checkOutput("job_col", job_col, exp_col);
        checkOutput("job_row", job_row, exp_row);
        q_due.push_back(ecount + 4);
        q_col.push_back(exp_col);
        q_row.push_back(exp_row);
        n_acc++;
        if (exp_col == TB_COLS - 1) begin
          exp_col = 0;
          exp_row = (exp_row == TB_ROWS - 1) ? 0 : exp_row + 1;
        end else begin
          exp_col++;
        end
      end
      exp_out = exp_out + int'(acc) - int'(res_valid && (exp_out != 0 || acc));
      @(posedge clk);
      @(negedge clk);
      frame_sync = 1'b0;
      res_valid  = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; frame_sync = 1'b0; obj_bus = '0; job_ready = 1'b0;
    res_valid = 1'b0; res_col = '0; res_row = '0; res_color = '0;

    // Reset state
    @(negedge clk);
    obj_bus = 128'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_job_valid", job_valid, 1'b0);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_addr", ram_addr, 13'd0);
    checkOutput("rst_ram_din", ram_din, 12'd0);
    checkOutput("rst_obj_snap", obj_snap, 128'd0);
    checkOutput("rst_outstanding", outstanding, 4'd0);
    checkOutput("rst_pulses", {frame_done, overrun, spurious}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    // Full frame, continuous ready, 3-cycle tracer
    $display("[TB] single frame");
    clearModel();
    expect_frames = 1;
    job_ready = 1'b1;
    applyStimulus(1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_job_valid", job_valid, 1'b1);
    checkOutput("start_snap", obj_snap, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    obj_bus = 128'hABCD;
    runTracer(30, -1, -1);
    checkOutput("f1_jobs", n_acc, 8);
    checkOutput("f1_writes", n_wr, 8);
    checkOutput("f1_done_count", n_done, 1);
    checkOutput("f1_done_latency", done_edge, last_res_edge + 2);
    checkOutput("f1_busy_end", busy, 1'b0);
    checkOutput("f1_out_end", outstanding, 4'd0);
    checkOutput("f1_snap_held", obj_snap, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

    // Result with nothing outstanding
    $display("[TB] spurious result in idle");
    res_valid = 1'b1; res_col = 7'd2; res_row = 6'd1; res_color = 12'hABC;
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    checkOutput("spur_pulse", spurious, 1'b1);
    checkOutput("spur_out", outstanding, 4'd0);
    checkOutput("spur_we", ram_we, 1'b1);
    checkOutput("spur_addr", ram_addr, {7'd2, 6'd1});
    checkOutput("spur_din", ram_din, 12'hABC);
    checkOutput("spur_busy", busy, 1'b0);
    @(negedge clk);
    checkOutput("spur_pulse_end", spurious, 1'b0);
    checkOutput("spur_we_end", ram_we, 1'b0);

    // Two syncs mid-frame: two overruns, exactly one queued frame
    $display("[TB] overrun");
    clearModel();
    expect_frames = 2;
    applyStimulus(1'b1, 128'hC1);
    obj_bus = 128'hC2;
    runTracer(10, 3, 6);
    checkOutput("ovr_pulses", n_over, 2);
    checkOutput("ovr_snap_frame1", obj_snap, 128'hC1);
    runTracer(40, -1, -1);
    checkOutput("ovr_pulses_total", n_over, 2);
    checkOutput("ovr_frames", n_done, 2);
    checkOutput("ovr_jobs", n_acc, 16);
    checkOutput("ovr_writes", n_wr, 16);
    checkOutput("ovr_snap_frame2", obj_snap, 128'hC2);
    checkOutput("ovr_busy_end", busy, 1'b0);

    // Credit limit with results withheld, then reset mid-frame
    $display("[TB] credit limit and abort");
    clearModel();
    applyStimulus(1'b1, 128'h77);
    for (int i = 0; i < 8; i++) begin
      if (job_valid && job_ready) n_acc++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("cred_jobs", n_acc, 4);
    checkOutput("cred_valid_low", job_valid, 1'b0);
    checkOutput("cred_out", outstanding, 4'd4);
    job_ready = 1'b0;
    res_valid = 1'b1; res_col = 7'd0; res_row = 6'd0; res_color = 12'h5A5;
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    checkOutput("cred_release_valid", job_valid, 1'b1);
    checkOutput("cred_release_col", job_col, 7'd0);
    checkOutput("cred_release_row", job_row, 6'd1);
    checkOutput("cred_release_out", outstanding, 4'd3);
    checkOutput("cred_release_we", ram_we, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("abort_we", ram_we, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_valid", job_valid, 1'b0);
    checkOutput("abort_out", outstanding, 4'd0);
    checkOutput("abort_snap", obj_snap, 128'd0);
    checkOutput("abort_addr_din", {ram_addr, ram_din}, 25'd0);
    @(negedge clk);
    rst = 1'b0;
    job_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 128'h99);
    checkOutput("restart_valid", job_valid, 1'b1);
    checkOutput("restart_col", job_col, 7'd0);
    checkOutput("restart_row", job_row, 6'd0);
    checkOutput("restart_out", outstanding, 4'd0);
    checkOutput("restart_snap", obj_snap, 128'h99);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
